// File: rtl/vlsu_pkg.sv
// Shared vector load/store unit types: per-beat transaction control record,
// the 4 KiB boundary constants and the AXI response error helper.
package vlsu_pkg;

  localparam int unsigned VlsuAddrWidth = 64;  // AXI byte address width
  localparam int unsigned VlsuBusNSize  = 5;   // log2(nibbles per 128-bit beat)

  // AXI bursts may not cross a 4 KiB byte boundary; request addresses are nibbles.
  localparam int unsigned BoundaryBytes = 4096;
  localparam int unsigned BndNibbles    = 2 * BoundaryBytes;
  localparam int unsigned BndBits       = $clog2(BndNibbles);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_AW,
    ST_BEATS,
    ST_DRAIN
  } sst_state_e;

  // One record per W beat, consumed by the store data controller.
  typedef struct packed {
    logic [VlsuAddrWidth:0]  addr;        // nibble address of the burst start
    logic                    isHead;      // first beat of the burst
    logic [7:0]              rmnBeat;     // beats left after this one
    logic [VlsuBusNSize:0]   lbN;         // valid nibbles in the last beat, 1..busNibbles
    logic                    isFinalTxn;  // burst belongs to the last slice of the request
  } txn_ctrl_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/seq_store_burst_calc.sv
// Combinational burst splitter: carves the next INCR burst out of the
// remaining request so it stays inside 4 KiB and within MaxBurstLen beats.
module seq_store_burst_calc
  import vlsu_pkg::*;
#(
  parameter int unsigned LenWidth    = 20,
  parameter int unsigned BusNSize    = 5,
  parameter int unsigned MaxBurstLen = 256
) (
  input  logic [BndBits-1:0]  addr_lo,   // low nibble-address bits, enough for offset and boundary
  input  logic [LenWidth-1:0] rmn_nbs,
  output logic [LenWidth-1:0] n,
  output logic [8:0]          beats,
  output logic [BusNSize:0]   lbn,
  output logic                fin
);

  // Wide enough for every intermediate: rmn_nbs, 8192 and off+N never overflow.
  localparam int unsigned CW = LenWidth + 2;

  logic [CW-1:0] off, bnd, mb, rmn, nn, mask;

  // N = min(remaining, distance to boundary, max burst minus head offset).
  always_comb begin
    mask  = CW'((1 << BusNSize) - 1);
    off   = CW'(addr_lo[BusNSize-1:0]);
    bnd   = CW'(BndNibbles) - CW'(addr_lo);
    mb    = CW'(MaxBurstLen << BusNSize) - off;
    rmn   = CW'(rmn_nbs);
    nn    = rmn;
    if (bnd < nn) nn = bnd;
    if (mb < nn)  nn = mb;
    n     = LenWidth'(nn);
    beats = 9'((off + nn + mask) >> BusNSize);
    lbn   = (BusNSize + 1)'(((off + nn - CW'(1)) & mask) + CW'(1));
    fin   = (nn == rmn);
  end

endmodule

// File: rtl/seq_store_txn_gen.sv
// Sequential store transaction generator: splits one nibble-addressed request
// into 4 KiB-safe AXI INCR bursts, issues AW plus per-beat control records,
// and tracks B responses until the request can be reported complete.
module seq_store_txn_gen
  import vlsu_pkg::*;
#(
  parameter int unsigned AxiDataWidth   = 128,  // must match VlsuBusNSize in vlsu_pkg
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned LenWidth       = 20,
  parameter int unsigned MaxBurstLen    = 256,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth:0]   req_addr_i,
  input  logic [LenWidth-1:0]     req_len_i,
  input  logic [AxiIdWidth-1:0]   req_id_i,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [AxiAddrWidth-1:0] aw_addr_o,
  output logic [7:0]              aw_len_o,
  output logic [2:0]              aw_size_o,
  output logic [1:0]              aw_burst_o,
  output logic [AxiIdWidth-1:0]   aw_id_o,
  output logic                    txn_ctrl_valid_o,
  input  logic                    txn_ctrl_ready_i,
  output txn_ctrl_t               txn_ctrl_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  output logic                    cmpl_valid_o,
  input  logic                    cmpl_ready_i,
  output logic                    cmpl_err_o
);

  localparam int unsigned BusNibbles = AxiDataWidth / 4;
  localparam int unsigned BusNSize   = $clog2(BusNibbles);
  localparam int unsigned ByteOff    = $clog2(AxiDataWidth / 8);
  localparam int unsigned OutW       = $clog2(MaxOutstanding + 1);

  sst_state_e              state, state_nxt;
  logic [AxiAddrWidth:0]   cur_addr;
  logic [LenWidth-1:0]     rmn_nbs, n_q, n_c;
  logic [AxiIdWidth-1:0]   id_q;
  logic [8:0]              beats_q, beats_c;
  logic [BusNSize:0]       lbn_q, lbn_c;
  logic                    fin_q, fin_c, err_q, head_q, out_en;
  logic [7:0]              beat_cnt;
  logic [OutW-1:0]         outstanding;
  logic                    req_hs, aw_hs, beat_hs, b_hs;

  seq_store_burst_calc #(
    .LenWidth    (LenWidth),
    .BusNSize    (BusNSize),
    .MaxBurstLen (MaxBurstLen)
  ) u_calc (
    .addr_lo (cur_addr[BndBits-1:0]),
    .rmn_nbs (rmn_nbs),
    .n       (n_c),
    .beats   (beats_c),
    .lbn     (lbn_c),
    .fin     (fin_c)
  );

  assign req_hs  = req_valid_i && req_ready_o;
  assign aw_hs   = aw_valid_o && aw_ready_i;
  assign beat_hs = txn_ctrl_valid_o && txn_ctrl_ready_i;
  assign b_hs    = b_valid_i && b_ready_o;

  // AW byte address is the burst start aligned down to the bus width.
  assign aw_addr_o  = {cur_addr[AxiAddrWidth:ByteOff+1], ByteOff'(0)};
  assign aw_len_o   = 8'(beats_q - 9'd1);
  assign aw_size_o  = 3'(ByteOff);
  assign aw_burst_o = 2'b01;
  assign aw_id_o    = id_q;
  assign b_ready_o  = (outstanding != '0);
  assign cmpl_err_o = err_q;
  assign txn_ctrl_o = '{addr: cur_addr, isHead: head_q, rmnBeat: beat_cnt,
                        lbN: lbn_q, isFinalTxn: fin_q};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and handshake valids; every valid decodes registered state only.
  always_comb begin
    state_nxt        = state;
    req_ready_o      = 1'b0;
    aw_valid_o       = 1'b0;
    txn_ctrl_valid_o = 1'b0;
    cmpl_valid_o     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = out_en;
        if (req_valid_i && out_en) state_nxt = ST_CALC;
      end
      ST_CALC: if (outstanding < OutW'(MaxOutstanding)) state_nxt = ST_AW;
      ST_AW: begin
        aw_valid_o = 1'b1;
        if (aw_ready_i) state_nxt = ST_BEATS;
      end
      ST_BEATS: begin
        txn_ctrl_valid_o = 1'b1;
        if (txn_ctrl_ready_i && beat_cnt == 8'd0) state_nxt = fin_q ? ST_DRAIN : ST_CALC;
      end
      ST_DRAIN: begin
        cmpl_valid_o = (outstanding == '0);
        if (cmpl_valid_o && cmpl_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request slice bookkeeping, burst latch, beat counter and B tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_en      <= 1'b0;
      cur_addr    <= '0;
      rmn_nbs     <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      n_q         <= '0;
      beats_q     <= '0;
      lbn_q       <= '0;
      fin_q       <= 1'b0;
      beat_cnt    <= '0;
      head_q      <= 1'b0;
      outstanding <= '0;
    end else begin
      // Holds req_ready low through the first post-reset edge.
      out_en <= 1'b1;
      if (req_hs) begin
        cur_addr <= req_addr_i;
        rmn_nbs  <= req_len_i;
        id_q     <= req_id_i;
        err_q    <= 1'b0;
      end
      // Latched so AW/beat payloads stay stable while the slice advances.
      if (state == ST_CALC) begin
        n_q     <= n_c;
        beats_q <= beats_c;
        lbn_q   <= lbn_c;
        fin_q   <= fin_c;
      end
      if (aw_hs) begin
        beat_cnt <= 8'(beats_q - 9'd1);
        head_q   <= 1'b1;
      end
      if (beat_hs) begin
        head_q <= 1'b0;
        if (beat_cnt != 8'd0) begin
          beat_cnt <= beat_cnt - 8'd1;
        end else if (!fin_q) begin
          cur_addr <= cur_addr + (AxiAddrWidth + 1)'(n_q);
          rmn_nbs  <= rmn_nbs - n_q;
        end
      end
      if (b_hs && resp_is_err(b_resp_i)) err_q <= 1'b1;
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + OutW'(1);
        2'b01:   outstanding <= outstanding - OutW'(1);
        default: ;
      endcase
    end
  end

  // A B with nothing outstanding is a slave protocol violation.
  assert property (@(posedge clk_i) disable iff (!rst_ni) b_valid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_seq_store_txn_gen.sv
// Directed bench for seq_store_txn_gen: aligned, unaligned, 4 KiB split,
// full-size burst, backpressure with outstanding limit and error, mid-request reset.
module tb_seq_store_txn_gen;
  import vlsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [64:0] req_addr = '0;
  logic [19:0] req_len = '0;
  logic [3:0]  req_id = '0;
  logic        aw_valid, aw_ready = 1'b0;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [3:0]  aw_id;
  logic        txn_valid, txn_ready = 1'b0;
  txn_ctrl_t   txn;
  logic        b_valid = 1'b0, b_ready;
  logic [1:0]  b_resp = '0;
  logic        cmpl_valid, cmpl_ready = 1'b0, cmpl_err;

  int vec = 0;
  int miscomp = 0;
  bit bp = 1'b0;

  always #5 clk = ~clk;

  seq_store_txn_gen #(.MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_id_i(req_id),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_len_o(aw_len),
    .aw_size_o(aw_size), .aw_burst_o(aw_burst), .aw_id_o(aw_id),
    .txn_ctrl_valid_o(txn_valid), .txn_ctrl_ready_i(txn_ready), .txn_ctrl_o(txn),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
    .cmpl_valid_o(cmpl_valid), .cmpl_ready_i(cmpl_ready), .cmpl_err_o(cmpl_err)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_req(input logic [64:0] a, input logic [19:0] l, input logic [3:0] id,
                          output bit to);
    to = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_len = l; req_id = id;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin to = 1'b0; break; end
      @(negedge clk);
    end
    if (!to) begin @(posedge clk); #1; end
    req_valid = 1'b0;
  endtask

  task automatic get_aw(output logic [63:0] a, output logic [7:0] l, output logic [3:0] id,
                        output bit to);
    to = 1'b1; a = '0; l = '0; id = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (aw_valid && (!bp || $urandom_range(0, 1) == 1)) begin
        a = aw_addr; l = aw_len; id = aw_id;
        aw_ready = 1'b1;
        @(posedge clk); #1;
        aw_ready = 1'b0;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic get_beat(output txn_ctrl_t t, output bit to);
    to = 1'b1; t = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txn_valid && (!bp || $urandom_range(0, 1) == 1)) begin
        t = txn;
        txn_ready = 1'b1;
        @(posedge clk); #1;
        txn_ready = 1'b0;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_b(input logic [1:0] r, output bit to);
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (b_ready) begin
        b_valid = 1'b1; b_resp = r;
        @(posedge clk); #1;
        b_valid = 1'b0;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic get_cmpl(output logic e, output bit to);
    to = 1'b1; e = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cmpl_valid) begin
        e = cmpl_err;
        cmpl_ready = 1'b1;
        @(posedge clk); #1;
        cmpl_ready = 1'b0;
        to = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({req_ready, aw_valid, txn_valid, b_ready, cmpl_valid, cmpl_err} !== 6'b0) begin
      miscomp++;
      $display("FAIL reset_outputs got rdy=%b aw=%b txn=%b b=%b cmpl=%b err=%b exp all 0",
               req_ready, aw_valid, txn_valid, b_ready, cmpl_valid, cmpl_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (req_ready !== 1'b1) begin
      miscomp++; $display("FAIL reset_req_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_aligned();
    bit to; logic [63:0] a; logic [7:0] l; logic [3:0] id; txn_ctrl_t t, e; logic er;
    send_req(65'h0, 20'd64, 4'd3, to);
    @(negedge clk);  // request accepted; this cycle is CALC
    vec++;
    if (to || aw_valid !== 1'b0) begin
      miscomp++; $display("FAIL aligned_latency_calc got to=%b aw_valid=%b exp 0", to, aw_valid);
    end
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'h0 || l !== 8'd1 || id !== 4'd3 || aw_size !== 3'd4 || aw_burst !== 2'b01) begin
      miscomp++;
      $display("FAIL aligned_aw got to=%b addr=%h len=%0d id=%0d size=%0d burst=%0d exp 0/1/3/4/1",
               to, a, l, id, aw_size, aw_burst);
    end
    for (int i = 0; i < 2; i++) begin
      get_beat(t, to);
      e = '{addr: 65'h0, isHead: (i == 0), rmnBeat: 8'(1 - i), lbN: 6'd32, isFinalTxn: 1'b1};
      vec++;
      if (to || t !== e) begin
        miscomp++; $display("FAIL aligned_beat%0d got to=%b %h exp %h", i, to, t, e);
      end
    end
    send_b(RESP_OKAY, to);
    get_cmpl(er, to);
    vec++;
    if (to || er !== 1'b0) begin
      miscomp++; $display("FAIL aligned_cmpl got to=%b err=%b exp 0", to, er);
    end
  endtask

  task automatic test_unaligned();
    bit to; logic [63:0] a; logic [7:0] l; logic [3:0] id; txn_ctrl_t t, e; logic er;
    send_req(65'h5, 20'd10, 4'd1, to);
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'h0 || l !== 8'd0) begin
      miscomp++; $display("FAIL unaligned_aw got to=%b addr=%h len=%0d exp 0/0", to, a, l);
    end
    get_beat(t, to);
    e = '{addr: 65'h5, isHead: 1'b1, rmnBeat: 8'd0, lbN: 6'd15, isFinalTxn: 1'b1};
    vec++;
    if (to || t !== e) begin
      miscomp++; $display("FAIL unaligned_beat got to=%b %h exp %h", to, t, e);
    end
    send_b(RESP_OKAY, to);
    get_cmpl(er, to);
    vec++;
    if (to || er !== 1'b0) begin
      miscomp++; $display("FAIL unaligned_cmpl got to=%b err=%b exp 0", to, er);
    end
  endtask

  task automatic test_4k_cross();
    bit to; logic [63:0] a; logic [7:0] l; logic [3:0] id; txn_ctrl_t t, e; logic er;
    send_req(65'h1FE0, 20'd64, 4'd2, to);
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'hFF0 || l !== 8'd0) begin
      miscomp++; $display("FAIL cross_aw1 got to=%b addr=%h len=%0d exp ff0/0", to, a, l);
    end
    get_beat(t, to);
    e = '{addr: 65'h1FE0, isHead: 1'b1, rmnBeat: 8'd0, lbN: 6'd32, isFinalTxn: 1'b0};
    vec++;
    if (to || t !== e) begin
      miscomp++; $display("FAIL cross_beat1 got to=%b %h exp %h", to, t, e);
    end
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'h1000 || l !== 8'd0 || id !== 4'd2) begin
      miscomp++; $display("FAIL cross_aw2 got to=%b addr=%h len=%0d id=%0d exp 1000/0/2", to, a, l, id);
    end
    get_beat(t, to);
    e = '{addr: 65'h2000, isHead: 1'b1, rmnBeat: 8'd0, lbN: 6'd32, isFinalTxn: 1'b1};
    vec++;
    if (to || t !== e) begin
      miscomp++; $display("FAIL cross_beat2 got to=%b %h exp %h", to, t, e);
    end
    send_b(RESP_OKAY, to);
    send_b(RESP_OKAY, to);
    get_cmpl(er, to);
    vec++;
    if (to || er !== 1'b0) begin
      miscomp++; $display("FAIL cross_cmpl got to=%b err=%b exp 0", to, er);
    end
  endtask

  task automatic test_full_burst();
    bit to; logic [63:0] a; logic [7:0] l; logic [3:0] id; txn_ctrl_t t, e; logic er;
    send_req(65'h0, 20'd8192, 4'd0, to);
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'h0 || l !== 8'd255) begin
      miscomp++; $display("FAIL full_aw got to=%b addr=%h len=%0d exp 0/255", to, a, l);
    end
    for (int i = 0; i < 256; i++) begin
      get_beat(t, to);
      e = '{addr: 65'h0, isHead: (i == 0), rmnBeat: 8'(255 - i), lbN: 6'd32, isFinalTxn: 1'b1};
      vec++;
      if (to || t !== e) begin
        miscomp++; $display("FAIL full_beat%0d got to=%b %h exp %h", i, to, t, e);
      end
    end
    send_b(RESP_OKAY, to);
    get_cmpl(er, to);
    vec++;
    if (to || er !== 1'b0) begin
      miscomp++; $display("FAIL full_cmpl got to=%b err=%b exp 0", to, er);
    end
  endtask

  task automatic test_backpressure_err();
    bit to; logic [63:0] a; logic [7:0] l; logic [3:0] id; txn_ctrl_t t, e; logic er;
    int aw_seen;
    bp = 1'b1;
    // Slices: 32 nibbles to the boundary, one full burst, then 10 nibbles.
    send_req(65'h1FE0, 20'd8234, 4'd5, to);
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'hFF0 || l !== 8'd0 || id !== 4'd5) begin
      miscomp++; $display("FAIL bp_aw1 got to=%b addr=%h len=%0d id=%0d exp ff0/0/5", to, a, l, id);
    end
    get_beat(t, to);
    e = '{addr: 65'h1FE0, isHead: 1'b1, rmnBeat: 8'd0, lbN: 6'd32, isFinalTxn: 1'b0};
    vec++;
    if (to || t !== e) begin
      miscomp++; $display("FAIL bp_beat1 got to=%b %h exp %h", to, t, e);
    end
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'h1000 || l !== 8'd255) begin
      miscomp++; $display("FAIL bp_aw2 got to=%b addr=%h len=%0d exp 1000/255", to, a, l);
    end
    for (int i = 0; i < 256; i++) begin
      get_beat(t, to);
      e = '{addr: 65'h2000, isHead: (i == 0), rmnBeat: 8'(255 - i), lbN: 6'd32, isFinalTxn: 1'b0};
      vec++;
      if (to || t !== e) begin
        miscomp++; $display("FAIL bp_beat2_%0d got to=%b %h exp %h", i, to, t, e);
      end
    end
    // Two bursts await B; the third AW must hold off.
    aw_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (aw_valid) aw_seen++;
    end
    vec++;
    if (aw_seen != 0) begin
      miscomp++; $display("FAIL bp_aw3_held got %0d aw_valid cycles exp 0", aw_seen);
    end
    send_b(RESP_OKAY, to);
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'h2000 || l !== 8'd0) begin
      miscomp++; $display("FAIL bp_aw3 got to=%b addr=%h len=%0d exp 2000/0", to, a, l);
    end
    get_beat(t, to);
    e = '{addr: 65'h4000, isHead: 1'b1, rmnBeat: 8'd0, lbN: 6'd10, isFinalTxn: 1'b1};
    vec++;
    if (to || t !== e) begin
      miscomp++; $display("FAIL bp_beat3 got to=%b %h exp %h", to, t, e);
    end
    send_b(RESP_SLVERR, to);
    send_b(RESP_OKAY, to);
    get_cmpl(er, to);
    vec++;
    if (to || er !== 1'b1) begin
      miscomp++; $display("FAIL bp_cmpl_err got to=%b err=%b exp 1", to, er);
    end
    bp = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit to; logic [63:0] a; logic [7:0] l; logic [3:0] id; txn_ctrl_t t, e; logic er;
    send_req(65'h0, 20'd64, 4'd7, to);
    get_aw(a, l, id, to);
    get_beat(t, to);  // one beat left, one burst outstanding
    @(negedge clk);
    vec++;
    if (txn_valid !== 1'b1) begin
      miscomp++; $display("FAIL rstmid_in_beats got txn_valid=%b exp 1", txn_valid);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({req_ready, aw_valid, txn_valid, b_ready, cmpl_valid, cmpl_err} !== 6'b0) begin
      miscomp++;
      $display("FAIL rstmid_outputs got rdy=%b aw=%b txn=%b b=%b cmpl=%b err=%b exp all 0",
               req_ready, aw_valid, txn_valid, b_ready, cmpl_valid, cmpl_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_req(65'h5, 20'd10, 4'd1, to);
    get_aw(a, l, id, to);
    vec++;
    if (to || a !== 64'h0 || l !== 8'd0 || id !== 4'd1) begin
      miscomp++; $display("FAIL rstmid_aw got to=%b addr=%h len=%0d id=%0d exp 0/0/1", to, a, l, id);
    end
    get_beat(t, to);
    e = '{addr: 65'h5, isHead: 1'b1, rmnBeat: 8'd0, lbN: 6'd15, isFinalTxn: 1'b1};
    vec++;
    if (to || t !== e) begin
      miscomp++; $display("FAIL rstmid_beat got to=%b %h exp %h", to, t, e);
    end
    send_b(RESP_OKAY, to);
    @(negedge clk);
    vec++;
    if (b_ready !== 1'b0) begin
      miscomp++; $display("FAIL rstmid_outstanding got b_ready=%b exp 0", b_ready);
    end
    get_cmpl(er, to);
    vec++;
    if (to || er !== 1'b0) begin
      miscomp++; $display("FAIL rstmid_cmpl got to=%b err=%b exp 0", to, er);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_4k_cross();
    test_full_burst();
    test_backpressure_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end

endmodule
